// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
// Holds the default regfile geometry, requester IDs and the two-way
// round-robin pick function used by the grant logic.
package regfile_wr_arbiter_pkg;

    localparam int unsigned RF_ADDR_W = 5;
    localparam int unsigned RF_DATA_W = 32;

    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_MUL = 1'b1;

    // Lone requester wins; on a tie the one that did not win last time wins.
    function automatic logic rr_pick(input logic v0, input logic v1, input logic last);
        logic pick;
        pick = REQ_ALU;
        if (v0 && v1) begin
            pick = ~last;
        end else if (v1) begin
            pick = REQ_MUL;
        end
        return pick;
    endfunction

endpackage

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// Two-input round-robin grant logic with its own last-grant pointer.
// Ports:
//   clk, resetn         clock, synchronous active-low reset
//   slot_free           the write stage can take a new entry this cycle
//   valid0, valid1      requester valids
//   ready0_c, ready1_c  combinational accepts (at most one high)
module regfile_wr_arbiter_rr_arb2
    import regfile_wr_arbiter_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic slot_free,
    input  logic valid0,
    input  logic valid1,
    output logic ready0_c,
    output logic ready1_c
);

    logic last_gnt_q;
    logic last_gnt_d;
    logic gnt_c;

    // Grant selection; readies are held low while reset is asserted.
    always_comb begin
        gnt_c      = rr_pick(valid0, valid1, last_gnt_q);
        ready0_c   = resetn & slot_free & valid0 & (gnt_c == REQ_ALU);
        ready1_c   = resetn & slot_free & valid1 & (gnt_c == REQ_MUL);
        last_gnt_d = last_gnt_q;
        if (ready0_c) begin
            last_gnt_d = REQ_ALU;
        end else if (ready1_c) begin
            last_gnt_d = REQ_MUL;
        end
    end

    // Pointer resets to REQ_MUL so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_gnt_q <= REQ_MUL;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the regfile write port between two writeback requesters through a
// one-entry registered write stage, with forwarding of the in-flight write.
// Ports:
//   clk, resetn                      clock, synchronous active-low reset
//   reqN_valid/addr/data, reqN_ready requester handshakes (N = 0, 1)
//   stall                            freezes the write stage
//   raddr1, raddr2                   regfile read addresses for forwarding
//   rf_wen/rf_waddr/rf_wdata         regfile write port
//   fwd1_hit, fwd2_hit, fwd_data     forwarding of the in-flight write
//   grant_id                         owner of the write-stage entry
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = RF_DATA_W,
    parameter int unsigned ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              stall,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic              rf_wen,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              fwd1_hit,
    output logic              fwd2_hit,
    output logic [DATA_W-1:0] fwd_data,
    output logic              grant_id
);

    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] pend_addr_q,  pend_addr_d;
    logic [DATA_W-1:0] pend_data_q,  pend_data_d;
    logic              pend_id_q,    pend_id_d;
    logic              slot_free_c;
    logic              xfer_c;

    // Stage is empty or drains this cycle.
    assign slot_free_c = ~pend_valid_q | ~stall;

    regfile_wr_arbiter_rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .resetn    (resetn),
        .slot_free (slot_free_c),
        .valid0    (req0_valid),
        .valid1    (req1_valid),
        .ready0_c  (req0_ready),
        .ready1_c  (req1_ready)
    );

    assign xfer_c = req0_ready | req1_ready;

    // Write-stage next state: load on transfer, drain when free, else hold.
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        pend_id_d    = pend_id_q;
        if (xfer_c) begin
            pend_valid_d = 1'b1;
            pend_addr_d  = req0_ready ? req0_addr : req1_addr;
            pend_data_d  = req0_ready ? req0_data : req1_data;
            pend_id_d    = req0_ready ? REQ_ALU : REQ_MUL;
        end else if (slot_free_c) begin
            pend_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            pend_id_q    <= REQ_ALU;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            pend_id_q    <= pend_id_d;
        end
    end

    // Writes to r0 are consumed but never reach the regfile.
    assign rf_wen   = pend_valid_q & ~stall & (pend_addr_q != ADDR_W'(0));
    assign rf_waddr = pend_addr_q;
    assign rf_wdata = pend_data_q;
    assign grant_id = pend_id_q;

    assign fwd1_hit = rf_wen & (rf_waddr == raddr1);
    assign fwd2_hit = rf_wen & (rf_waddr == raddr2);
    assign fwd_data = rf_wdata;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against a
// behavioural model of the write stage.
module tb_regfile_wr_arbiter;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    logic          clk;
    logic          resetn;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          stall;
    logic [AW-1:0] raddr1, raddr2;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          fwd1_hit, fwd2_hit;
    logic [DW-1:0] fwd_data;
    logic          grant_id;

    regfile_wr_arbiter dut (
        .clk        (clk),
        .resetn     (resetn),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .stall      (stall),
        .raddr1     (raddr1),
        .raddr2     (raddr2),
        .rf_wen     (rf_wen),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .fwd1_hit   (fwd1_hit),
        .fwd2_hit   (fwd2_hit),
        .fwd_data   (fwd_data),
        .grant_id   (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; outputs sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Behavioural model: the entry waiting for the write port, plus who won last.
    bit            chk_en = 1'b0;
    bit            m_busy = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    bit            m_owner = 1'b0;
    bit            m_last_winner = 1'b1;

    always @(negedge clk) begin
        bit winner, room, acc0, acc1, writes;
        if (chk_en) begin
            // Lone requester wins; on contention, whoever did not win last time.
            if (req0_valid && req1_valid) winner = !m_last_winner;
            else                          winner = req1_valid;
            room   = !m_busy || !stall;
            acc0   = resetn && room && req0_valid && (winner == 1'b0);
            acc1   = resetn && room && req1_valid && (winner == 1'b1);
            writes = m_busy && !stall && (m_addr != 0);

            chk("req0_ready", DW'(req0_ready), DW'(acc0));
            chk("req1_ready", DW'(req1_ready), DW'(acc1));
            chk("rf_wen",     DW'(rf_wen),     DW'(writes));
            chk("rf_waddr",   DW'(rf_waddr),   DW'(m_addr));
            chk("rf_wdata",   rf_wdata,        m_data);
            chk("grant_id",   DW'(grant_id),   DW'(m_owner));
            chk("fwd1_hit",   DW'(fwd1_hit),   DW'(writes && (m_addr == raddr1)));
            chk("fwd2_hit",   DW'(fwd2_hit),   DW'(writes && (m_addr == raddr2)));
            chk("fwd_data",   fwd_data,        m_data);

            if (!resetn) begin
                m_busy = 1'b0; m_addr = '0; m_data = '0; m_owner = 1'b0; m_last_winner = 1'b1;
            end else if (acc0 || acc1) begin
                m_busy        = 1'b1;
                m_addr        = acc0 ? req0_addr : req1_addr;
                m_data        = acc0 ? req0_data : req1_data;
                m_owner       = acc1;
                m_last_winner = acc1;
            end else if (room) begin
                m_busy = 1'b0;
            end
        end
    end

    logic r0s, r1s;

    initial begin
        resetn = 1'b0; stall = 1'b0;
        req0_valid = 1'b1; req0_addr = AW'(3); req0_data = DW'(32'h11);
        req1_valid = 1'b1; req1_addr = AW'(4); req1_data = DW'(32'h22);
        raddr1 = '0; raddr2 = '0;
        step();
        chk_en = 1'b1;

        // Reset held with both requesters valid.
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("rst_wen",    DW'(rf_wen),     '0);
            chk("rst_ready0", DW'(req0_ready), '0);
            chk("rst_ready1", DW'(req1_ready), '0);
            chk("rst_gid",    DW'(grant_id),   '0);
            step();
        end
        resetn = 1'b1;
        sample();
        chk("first_tie_r0", DW'(req0_ready), DW'(1));
        chk("first_tie_r1", DW'(req1_ready), '0);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();

        // Single write to r5, then forwarding during the write cycle only.
        req0_valid = 1'b1; req0_addr = AW'(5); req0_data = DW'(32'h3F);
        sample();
        chk("single_ready", DW'(req0_ready), DW'(1));
        step();
        req0_valid = 1'b0; raddr1 = AW'(5); raddr2 = AW'(6);
        sample();
        chk("single_wen",   DW'(rf_wen),   DW'(1));
        chk("single_waddr", DW'(rf_waddr), DW'(5));
        chk("single_wdata", rf_wdata,      DW'(32'h3F));
        chk("fwd1_on",      DW'(fwd1_hit), DW'(1));
        chk("fwd2_off",     DW'(fwd2_hit), '0);
        chk("fwd_data_3f",  fwd_data,      DW'(32'h3F));
        step();
        sample();
        chk("fwd1_after",   DW'(fwd1_hit), '0);
        chk("wen_after",    DW'(rf_wen),   '0);
        step();

        // Continuous contention: requester 0 won last, so requester 1 goes first.
        req0_valid = 1'b1; req0_addr = AW'(1); req0_data = DW'(32'hA);
        req1_valid = 1'b1; req1_addr = AW'(2); req1_data = DW'(32'hB);
        for (int i = 0; i < 6; i++) begin
            sample();
            chk("cont_ready1", DW'(req1_ready), DW'(i % 2 == 0));
            chk("cont_ready0", DW'(req0_ready), DW'(i % 2 == 1));
            if (i > 0) chk("cont_gid", DW'(grant_id), DW'(i % 2 == 1));
            step();
        end

        // Stall with an entry pending, then release with a same-cycle accept.
        req1_valid = 1'b0;
        req0_addr = AW'(7); req0_data = DW'(32'h55);
        sample();
        chk("stall_acc", DW'(req0_ready), DW'(1));
        step();
        req0_valid = 1'b0; stall = 1'b1;
        req1_valid = 1'b1; req1_addr = AW'(9); req1_data = DW'(32'h66);
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("stall_wen",    DW'(rf_wen),     '0);
            chk("stall_ready1", DW'(req1_ready), '0);
            chk("stall_hold",   DW'(rf_waddr),   DW'(7));
            step();
        end
        stall = 1'b0;
        sample();
        chk("unstall_wen",   DW'(rf_wen),     DW'(1));
        chk("unstall_waddr", DW'(rf_waddr),   DW'(7));
        chk("unstall_wdata", rf_wdata,        DW'(32'h55));
        chk("unstall_acc",   DW'(req1_ready), DW'(1));
        step();
        req1_valid = 1'b0;
        sample();
        chk("next_waddr", DW'(rf_waddr), DW'(9));
        chk("next_gid",   DW'(grant_id), DW'(1));
        step();

        // Write to r0 is accepted but suppressed.
        req1_valid = 1'b1; req1_addr = AW'(0); req1_data = DW'(32'hFFFF);
        raddr1 = AW'(0); raddr2 = AW'(0);
        sample();
        chk("r0_ready", DW'(req1_ready), DW'(1));
        step();
        req1_valid = 1'b0;
        sample();
        chk("r0_wen",  DW'(rf_wen),   '0);
        chk("r0_fwd1", DW'(fwd1_hit), '0);
        chk("r0_fwd2", DW'(fwd2_hit), '0);
        chk("r0_gid",  DW'(grant_id), DW'(1));
        step();

        // Randomized traffic; requesters hold their request until accepted.
        for (int c = 0; c < 3000; c++) begin
            sample();
            r0s = req0_ready;
            r1s = req1_ready;
            step();
            if (!req0_valid || r0s) begin
                req0_valid = ($urandom_range(2) != 0);
                req0_addr  = AW'($urandom_range(7));
                req0_data  = $urandom;
            end
            if (!req1_valid || r1s) begin
                req1_valid = ($urandom_range(2) != 0);
                req1_addr  = AW'($urandom_range(7));
                req1_data  = $urandom;
            end
            stall  = ($urandom_range(3) == 0);
            resetn = ($urandom_range(99) != 0);
            raddr1 = AW'($urandom_range(7));
            raddr2 = AW'($urandom_range(7));
        end
        sample();
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the register file's single write port (wen/waddr/wdata) between two writeback requesters: req0 (ALU writeback) and req1 (multiply/load writeback).
- Uses round-robin arbitration with valid/ready handshakes and a one-entry registered write stage.
- Holds that stage while a stall is asserted.
- Provides same-cycle read forwarding of the in-flight write for the regfile's two read ports.

Parameters:
- DATA_W, 32, width of write data and forwarded data.
- ADDR_W, 5, register address width (32 registers).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- req0_valid  in  1  requester 0 has a write pending.
- req0_addr  in  ADDR_W  requester 0 destination register.
- req0_data  in  DATA_W  requester 0 write data.
- req0_ready  out  1  requester 0 write accepted this cycle.
- req1_valid  in  1  requester 1 has a write pending.
- req1_addr  in  ADDR_W  requester 1 destination register.
- req1_data  in  DATA_W  requester 1 write data.
- req1_ready  out  1  requester 1 write accepted this cycle.
- stall  in  1  freeze the write stage; no regfile write occurs while high.
- raddr1  in  ADDR_W  regfile read port 1 address, for forwarding compare.
- raddr2  in  ADDR_W  regfile read port 2 address, for forwarding compare.
- rf_wen  out  1  regfile write enable.
- rf_waddr  out  ADDR_W  regfile write address.
- rf_wdata  out  DATA_W  regfile write data.
- fwd1_hit  out  1  the in-flight write targets raddr1.
- fwd2_hit  out  1  the in-flight write targets raddr2.
- fwd_data  out  DATA_W  data to substitute on a forwarding hit (equals rf_wdata).
- grant_id  out  1  which requester owns the current write-stage entry.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on resetn.
- State:
  - pend_valid, pend_addr, pend_data, pend_id: the write stage.
  - last_gnt: round-robin pointer.
- Reset (resetn=0 at an edge):
  - pend_valid=0, pend_addr=0, pend_data=0, pend_id=0.
  - last_gnt=1, so req0 wins the first tie.
  - Consequently rf_wen=0, rf_waddr=0, rf_wdata=0, grant_id=0, fwd1_hit=0, fwd2_hit=0, fwd_data=0.
  - Reset mid-operation discards any pending entry with no write; requesters must re-present.
- Slot free: slot_free = ~pend_valid | ~stall. The stage either is empty or drains this cycle.
- Arbitration (combinational):
  - Only req0 valid -> grant 0. Only req1 valid -> grant 1.
  - Both valid -> grant the one that is not last_gnt.
  - reqN_ready = grant==N & reqN_valid & slot_free. At most one ready per cycle.
- Handshake:
  - A transfer occurs when reqN_valid & reqN_ready.
  - On transfer: pend_* <= request fields, pend_valid<=1, pend_id<=N, last_gnt<=N.
  - If slot_free but no transfer: pend_valid<=0. last_gnt is unchanged.
  - If stall & pend_valid: all pend_* are held.
- Requester rule: requesters hold valid, addr and data stable until ready. The arbiter does not check this.
- Write output:
  - rf_wen = pend_valid & ~stall & (pend_addr!=0). Writes to r0 are accepted and consumed but suppressed.
  - rf_waddr=pend_addr, rf_wdata=pend_data, grant_id=pend_id.
  - Latency: accept at edge k -> rf_wen high during cycle k+1 -> regfile updated at edge k+2.
  - Sustained throughput is 1 write per cycle with no stall.
- Forwarding (combinational):
  - fwdX_hit = rf_wen & (rf_waddr==raddrX). Never asserted for r0 or while stalled.
  - fwd_data = rf_wdata.
  - A read the cycle after the write edge sees the regfile value, so forwarding covers exactly one cycle.
- Simultaneous events:
  - Stall rising while an entry is pending: the entry is held and both readies are 0.
  - Stall falling: the entry is written that cycle, and a new request may be accepted in the same cycle.
  - Both requesters targeting the same register: ordering follows the grant order; the later write wins in the regfile.
- Fairness: under continuous contention, grants alternate 0,1,0,1. No requester waits more than one transfer.

Decomposition:
- Shared package holds:
  - RF_ADDR_W=5, RF_DATA_W=32.
  - Requester ID constants REQ_ALU=0, REQ_MUL=1.
- Optional sub-module rr_arb2: two-input round-robin grant logic with its last_gnt register.
- Everything else stays in the top module.

Test Plan:
- Reset: hold resetn=0 for 3 cycles with both valids=1 -> rf_wen=0, both readies=0, grant_id=0; after release, req0 is accepted first.
- Single write: req0 {addr=5, data=32'h3F} -> req0_ready=1 at cycle k, rf_wen=1 with waddr=5, wdata=32'h3F at k+1; regfile r5 reads 32'h3F from k+2.
- Contention: both valid continuously (req0 addr=1 data=0xA, req1 addr=2 data=0xB) -> grant_id sequence 0,1,0,1; each ready pulses every other cycle.
- Stall: pending entry {addr=7, data=0x55}, stall high 4 cycles -> rf_wen=0 and readies=0 throughout; on release, rf_wen=1 with addr=7 and a new accept in the same cycle.
- r0 write: req1 {addr=0, data=0xFFFF} -> req1_ready=1, rf_wen stays 0, fwd hits 0.
- Forwarding: in-flight write addr=5 data=0x3F with raddr1=5 and raddr2=6 -> fwd1_hit=1, fwd2_hit=0, fwd_data=0x3F; the next cycle with no write -> fwd1_hit=0.
